fwd_mux_pipe: RTL and testbench

FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

---
 rtl/fwd_mux_pkg.sv | 14 +
 rtl/fwd_mux_sel.sv | 33 +++
 rtl/fwd_mux_pipe.sv | 134 +++++++++++++
 tb/tb_fwd_mux_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_mux_pkg.sv
// fwd_mux_pkg -- shared types and constants for the forwarding mux pipe.
//   skid_st_e : occupancy of the 2-entry skid buffer (EMPTY / ONE / FULL)
//   ERRCNT_W  : width of the optional out-of-range select counter
package fwd_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_st_e;

  localparam int ERRCNT_W = 16;

endpackage

// File: rtl/fwd_mux_sel.sv
// fwd_mux_sel -- purely combinational N_SRC:1 source select.
//   in_data : N_SRC packed sources, source k at [k*WIDTH +: WIDTH]
//   sel     : source index
//   data    : selected source; any index >= N_SRC falls back to source N_SRC-1
//   oor     : high when sel is out of range (>= N_SRC)
module fwd_mux_sel #(
  parameter  int WIDTH = 32,
  parameter  int N_SRC = 5,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       data,
  output logic                   oor
);

  logic [N_SRC-1:0][WIDTH-1:0] src;
  assign src = in_data;

  // Start from the out-of-range fallback; an in-range match overrides it.
  // When N_SRC is a power of two no index is out of range and oor stays 0.
  always_comb begin
    data = src[N_SRC-1];
    oor  = 1'b1;
    for (int k = 0; k < N_SRC; k++) begin
      if (int'(sel) == k) begin
        data = src[k];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fwd_mux_pipe.sv
// fwd_mux_pipe -- select one of N_SRC sources and forward it through a
// 2-entry skid buffer with valid/ready handshakes on both sides.
//
// Optional feature: define FWD_MUX_PIPE_ERRCNT_EN to add err_cnt, a
// saturating count of sel_err pulses (cleared only by reset).
//
// Ports
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   in_data      : N_SRC packed sources, source k at [k*WIDTH +: WIDTH]
//   in_sel       : source index; >= N_SRC selects source N_SRC-1
//   in_valid     : input beat valid
//   in_ready     : buffer can take a beat (state != FULL, registered only)
//   out_data     : oldest unsent beat, 0 while empty
//   out_valid    : out_data valid
//   out_ready    : consumer takes out_data
//   flush        : synchronous discard of all buffered beats (top priority)
//   sel_err      : one-cycle pulse after an accepted out-of-range beat
//   err_cnt      : (FWD_MUX_PIPE_ERRCNT_EN only) saturating sel_err count
//
// SEL_W is derived; leave it at its default.
module fwd_mux_pipe
  import fwd_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_SRC = 5,   // legal range 2..16
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_SRC*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   sel_err
`ifdef FWD_MUX_PIPE_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]    err_cnt
`endif
);

  skid_st_e         st, st_nx;
  logic [WIDTH-1:0] head_q, head_nx;   // entry presented on out_data
  logic [WIDTH-1:0] skid_q, skid_nx;   // second entry, only live in FULL
  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic             acc, xfer;

  fwd_mux_sel #(
    .WIDTH (WIDTH),
    .N_SRC (N_SRC)
  ) u_sel (
    .in_data (in_data),
    .sel     (in_sel),
    .data    (sel_data),
    .oor     (sel_oor)
  );

  // Handshake outputs depend on registered state only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (st != FULL);
  assign out_valid = (st != EMPTY);
  assign out_data  = (st == EMPTY) ? '0 : head_q;

  assign acc  = in_valid && in_ready;
  assign xfer = out_valid && out_ready;

  always_comb begin
    st_nx   = st;
    head_nx = head_q;
    skid_nx = skid_q;
    if (flush) begin
      st_nx = EMPTY;
    end else begin
      unique case (st)
        EMPTY: begin
          if (acc) begin
            st_nx   = ONE;
            head_nx = sel_data;
          end
        end
        ONE: begin
          case ({acc, xfer})
            2'b10: begin
              st_nx   = FULL;
              skid_nx = sel_data;
            end
            2'b01: st_nx = EMPTY;
            // head leaves and the new beat takes its place: no bubble
            2'b11: head_nx = sel_data;
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a transfer can happen; the skid
          // entry becomes the head to keep order.
          if (xfer) begin
            st_nx   = ONE;
            head_nx = skid_q;
          end
        end
        default: st_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      sel_err <= 1'b0;
    end else begin
      st      <= st_nx;
      head_q  <= head_nx;
      skid_q  <= skid_nx;
      // a beat that flush throws away never reports an error
      sel_err <= acc && !flush && sel_oor;
    end
  end

`ifdef FWD_MUX_PIPE_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_cnt <= '0;
    else if (sel_err && (err_cnt != '1))
      err_cnt <= err_cnt + ERRCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// tb_fwd_mux_pipe -- directed self-checking bench for fwd_mux_pipe
// (WIDTH=32, N_SRC=5). Covers err_cnt when FWD_MUX_PIPE_ERRCNT_EN is defined.
module tb_fwd_mux_pipe;

  localparam int WIDTH = 32;
  localparam int N_SRC = 5;
  localparam int SEL_W = 3;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic [N_SRC-1:0][WIDTH-1:0] src;
  logic [N_SRC*WIDTH-1:0]      in_data;
  logic [SEL_W-1:0]            in_sel;
  logic                        in_valid, in_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_valid, out_ready;
  logic                        flush, sel_err;
`ifdef FWD_MUX_PIPE_ERRCNT_EN
  logic [15:0]                 err_cnt;
  logic [15:0]                 exp_cnt;
`endif

  int checks = 0;
  int errors = 0;

  assign in_data = src;

  always #5 clk = ~clk;

  fwd_mux_pipe #(.WIDTH(WIDTH), .N_SRC(N_SRC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .sel_err   (sel_err)
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    src = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %0h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h want 1", in_ready); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_selerr got %0h want 0", sel_err); end
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    exp_cnt = 16'h0;
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL rst_errcnt got %0h want %0h", err_cnt, exp_cnt); end
`endif
    // a beat offered during reset must be ignored
    src[0] = 32'h11; in_valid = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got %0h want 0", out_valid); end
    #2 reset_n = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin errors++; $display("FAIL rst_first_beat got %0h/%0h want 1/11", out_valid, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_stream();
    src[2] = 32'h1234_5678; in_sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin errors++; $display("FAIL stream_beat%0d got %0h/%0h want 1/12345678", i, out_valid, out_data); end
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL stream_end got %0h/%0h want 0/0", out_valid, out_data); end
  endtask

  task automatic test_select();
    for (int k = 0; k < N_SRC; k++) src[k] = 32'hC0DE_0000 + k;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < N_SRC; k++) begin
      in_sel = SEL_W'(k);
      cyc();
      checks++; if (out_data !== (32'hC0DE_0000 + k) || sel_err !== 1'b0) begin errors++; $display("FAIL select_src%0d got %0h err %0h want %0h err 0", k, out_data, sel_err, 32'hC0DE_0000 + k); end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_sel = 3'd0;
    src[0] = 32'hA; in_valid = 1'b1;
    cyc();
    checks++; if (out_data !== 32'hA || in_ready !== 1'b1) begin errors++; $display("FAIL bp_one got %0h rdy %0h want a rdy 1", out_data, in_ready); end
    src[0] = 32'hB;
    cyc();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'hA) begin errors++; $display("FAIL bp_full got rdy %0h data %0h want rdy 0 data a", in_ready, out_data); end
    // C is offered while full; it must wait
    src[0] = 32'hC;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin errors++; $display("FAIL bp_hold got %0h/%0h want 1/a", out_valid, out_data); end
    out_ready = 1'b1;
    cyc();
    checks++; if (out_data !== 32'hB || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_a got %0h rdy %0h want b rdy 1", out_data, in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hC) begin errors++; $display("FAIL bp_c got %0h/%0h want 1/c", out_valid, out_data); end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_oor();
    src[4] = 32'hDEAD_BEEF; in_sel = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    checks++; if (out_data !== 32'hDEAD_BEEF || sel_err !== 1'b1) begin errors++; $display("FAIL oor7 got %0h err %0h want deadbeef err 1", out_data, sel_err); end
    in_sel = 3'd4;
    cyc();
    checks++; if (out_data !== 32'hDEAD_BEEF || sel_err !== 1'b0) begin errors++; $display("FAIL oor_in4 got %0h err %0h want deadbeef err 0", out_data, sel_err); end
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL oor_cnt1 got %0h want %0h", err_cnt, exp_cnt); end
`endif
    in_sel = 3'd5;
    cyc();
    checks++; if (out_data !== 32'hDEAD_BEEF || sel_err !== 1'b1) begin errors++; $display("FAIL oor5 got %0h err %0h want deadbeef err 1", out_data, sel_err); end
    in_valid = 1'b0;
    cyc();
    checks++; if (sel_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL oor_end got err %0h vld %0h want 0/0", sel_err, out_valid); end
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL oor_cnt2 got %0h want %0h", err_cnt, exp_cnt); end
`endif
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_sel = 3'd1; in_valid = 1'b1;
    src[1] = 32'hF1;
    cyc();
    src[1] = 32'hF2;
    cyc();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_pre_full got %0h want 0", in_ready); end
    flush = 1'b1; in_sel = 3'd7;
    cyc();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || sel_err !== 1'b0) begin errors++; $display("FAIL fl_full got vld %0h rdy %0h data %0h err %0h want 0/1/0/0", out_valid, in_ready, out_data, sel_err); end
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL fl_full_after got vld %0h err %0h want 0/0", out_valid, sel_err); end
    // from ONE the out-of-range beat would be accepted without flush
    in_sel = 3'd1; in_valid = 1'b1;
    cyc();
    flush = 1'b1; in_sel = 3'd7;
    cyc();
    checks++; if (out_valid !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL fl_one got vld %0h err %0h want 0/0", out_valid, sel_err); end
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL fl_one_after got vld %0h err %0h want 0/0", out_valid, sel_err); end
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL fl_cnt got %0h want %0h", err_cnt, exp_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_sel = 3'd3; in_valid = 1'b1;
    src[3] = 32'h33;
    cyc();
    cyc();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_pre_full got %0h want 0", in_ready); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_async got vld %0h data %0h rdy %0h want 0/0/1", out_valid, out_data, in_ready); end
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    exp_cnt = 16'h0;
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL rm_cnt got %0h want 0", err_cnt); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_discard got %0h want 0", out_valid); end
  endtask

`ifdef FWD_MUX_PIPE_ERRCNT_EN
  task automatic test_saturate();
    in_sel = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65540) cyc();
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %0h want ffff", err_cnt); end
    repeat (3) cyc();
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h want ffff", err_cnt); end
    in_valid = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_select();
    test_backpressure();
    test_oor();
    test_flush();
    test_reset_mid();
`ifdef FWD_MUX_PIPE_ERRCNT_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
